// File: rtl/a2d_spi_resp.sv
`default_nettype none
// ============================================================================
// Module   : a2d_spi_resp
// Brief    : SPI slave that models an A2D converter. Each frame shifts a 16-bit
//            command in on MOSI while returning, on MISO, the 12-bit value of
//            the channel commanded in the previous frame.
// Options  : define A2D_RESP_CHK_EN to compile in protocol checking (cmd_err).
// Revision : 1.0 - initial release
// ============================================================================
module a2d_spi_resp #(
  parameter int NUM_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  output logic [2:0]  chnl,
  output logic        cmd_rdy,
  output logic        cmd_err
);

  localparam logic [4:0] c_CNT_LAST = 5'(NUM_BITS);
  // Bits [15:14] of the command only matter to the format check.
`ifdef A2D_RESP_CHK_EN
  localparam int c_RX_W = 16;
`else
  localparam int c_RX_W = 14;
`endif

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  logic              r_ss_s1, r_ss_s2, r_ss_d;
  logic              r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic              r_mosi_s1, r_mosi_s2;
  state_t            r_state, w_state_nxt;
  logic [15:0]       r_tx;
  logic [c_RX_W-1:0] r_rx;
  logic [4:0]        r_cnt;
  logic [2:0]        r_chnl;
  logic              r_cmd_rdy;
  logic [11:0]       w_ld_val;
  logic              w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic              w_start, w_end, w_done, w_rise_ok, w_fall_ok, w_miso;

  // Synchronize the asynchronous SPI pins; reset to the bus idle levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_s1   <= 1'b1;
      r_ss_s2   <= 1'b1;
      r_ss_d    <= 1'b1;
      r_sclk_s1 <= 1'b1;
      r_sclk_s2 <= 1'b1;
      r_sclk_d  <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_ss_s1   <= SS_n;
      r_ss_s2   <= r_ss_s1;
      r_ss_d    <= r_ss_s2;
      r_sclk_s1 <= SCLK;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_ss_fall   =  r_ss_d   & ~r_ss_s2;
  assign w_ss_rise   = ~r_ss_d   &  r_ss_s2;
  assign w_sclk_rise = ~r_sclk_d &  r_sclk_s2;
  assign w_sclk_fall =  r_sclk_d & ~r_sclk_s2;

  // Response value for the channel held from the last completed command.
  always_comb begin
    w_ld_val = 12'h000;
    case (r_chnl)
      3'd0:    w_ld_val = lft_ld;
      3'd4:    w_ld_val = rght_ld;
      3'd5:    w_ld_val = batt;
      default: w_ld_val = 12'h000;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle datapath strobes; an SS_n rise masks any
  // SCLK edge seen in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_rise_ok   = 1'b0;
    w_fall_ok   = 1'b0;
    w_miso      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt = S_SHIFT;
          w_start     = 1'b1;
        end
      end
      S_SHIFT: begin
        w_miso = r_tx[15];
        if (w_ss_rise) begin
          w_state_nxt = S_IDLE;
          w_end       = 1'b1;
        end else if (w_sclk_rise) begin
          w_rise_ok = (r_cnt != c_CNT_LAST);
        end else if (w_sclk_fall) begin
          // The fall that precedes the first rise must not shift out bit 15.
          w_fall_ok = (r_cnt != 5'd0);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_done = w_end & (r_cnt == c_CNT_LAST);

  // Shift registers, bit counter and the command result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx      <= 16'h0000;
      r_rx      <= '0;
      r_cnt     <= 5'd0;
      r_chnl    <= 3'd0;
      r_cmd_rdy <= 1'b0;
    end else begin
      r_cmd_rdy <= w_done;
      if (w_start) begin
        r_tx  <= {4'h0, w_ld_val};
        r_cnt <= 5'd0;
      end else if (w_fall_ok) begin
        r_tx <= {r_tx[14:0], 1'b0};
      end
      if (w_rise_ok) begin
        r_rx  <= {r_rx[c_RX_W-2:0], r_mosi_s2};
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_done) begin
        r_chnl <= r_rx[13:11];
      end
    end
  end

  assign MISO    = w_miso;
  assign chnl    = r_chnl;
  assign cmd_rdy = r_cmd_rdy;

`ifdef A2D_RESP_CHK_EN
  logic w_abort, w_over, w_fmt_bad, r_err;

  assign w_abort   = w_end & (r_cnt != c_CNT_LAST);
  assign w_over    = (r_state == S_SHIFT) & ~w_ss_rise & w_sclk_rise &
                     (r_cnt == c_CNT_LAST);
  assign w_fmt_bad = (|r_rx[15:14]) | (|r_rx[10:0]);

  // Sticky protocol error: aborted frame, overlong frame or malformed command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_abort | w_over | (w_done & w_fmt_bad)) begin
      r_err <= 1'b1;
    end
  end

  assign cmd_err = r_err;
`else
  assign cmd_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_a2d_spi_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_a2d_spi_resp
// Brief    : Directed self-checking bench for a2d_spi_resp. Expected cmd_err
//            follows A2D_RESP_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a2d_spi_resp;

`ifdef A2D_RESP_CHK_EN
  localparam logic c_CHK = 1'b1;
`else
  localparam logic c_CHK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic [2:0]  chnl;
  logic        cmd_rdy;
  logic        cmd_err;

  int n_checks = 0;
  int n_errors = 0;

  a2d_spi_resp #(.NUM_BITS(16)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .lft_ld  (lft_ld),
    .rght_ld (rght_ld),
    .batt    (batt),
    .chnl    (chnl),
    .cmd_rdy (cmd_rdy),
    .cmd_err (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame with nrise SCLK rises; MISO is sampled just before each rise.
  task automatic spi_frame(input logic [15:0] cmd, input int nrise,
                           output logic [15:0] rx_word, output logic extra_bit,
                           output int rdy_cnt);
    rx_word   = 16'h0000;
    extra_bit = 1'b0;
    rdy_cnt   = 0;
    SS_n = 1'b0;
    wait_clks(10);
    for (int i = 0; i < nrise; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      wait_clks(5);
      if (i < 16) rx_word = {rx_word[14:0], MISO};
      else        extra_bit = MISO;
      SCLK = 1'b1;
      wait_clks(5);
    end
    SS_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cmd_rdy) rdy_cnt++;
    end
    wait_clks(4);
  endtask

  // Guard against a stalled run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] w_word;
    logic        w_bit;
    int          w_rdy;

    rst_n   = 1'b0;
    SS_n    = 1'b1;
    SCLK    = 1'b1;
    MOSI    = 1'b0;
    lft_ld  = 12'hABC;
    rght_ld = 12'h123;
    batt    = 12'hFFF;
    wait_clks(3);
    check_val("rst_miso",  16'(MISO),    16'h0);
    check_val("rst_chnl",  16'(chnl),    16'h0);
    check_val("rst_rdy",   16'(cmd_rdy), 16'h0);
    check_val("rst_err",   16'(cmd_err), 16'h0);
    rst_n = 1'b1;
    wait_clks(5);

    // Frame 1: returns channel 0 (lft_ld), commands channel 4.
    spi_frame(16'h2000, 16, w_word, w_bit, w_rdy);
    check_val("f1_miso", w_word,          16'h0ABC);
    check_val("f1_chnl", 16'(chnl),       16'd4);
    check_val("f1_rdy",  16'(w_rdy),      16'd1);
    check_val("f1_err",  16'(cmd_err),    16'h0);
    check_val("f1_idle_miso", 16'(MISO),  16'h0);

    // Frame 2: returns rght_ld, commands channel 5.
    spi_frame(16'h2800, 16, w_word, w_bit, w_rdy);
    check_val("f2_miso", w_word,     16'h0123);
    check_val("f2_chnl", 16'(chnl),  16'd5);
    check_val("f2_rdy",  16'(w_rdy), 16'd1);

    // Frame 3: returns batt, commands unmapped channel 7.
    spi_frame(16'h3800, 16, w_word, w_bit, w_rdy);
    check_val("f3_miso", w_word,     16'h0FFF);
    check_val("f3_chnl", 16'(chnl),  16'd7);
    check_val("f3_rdy",  16'(w_rdy), 16'd1);

    // Aborted frame after 9 rises: channel held, no ready pulse.
    spi_frame(16'h2000, 9, w_word, w_bit, w_rdy);
    check_val("ab_chnl", 16'(chnl),    16'd7);
    check_val("ab_rdy",  16'(w_rdy),   16'd0);
    check_val("ab_err",  16'(cmd_err), 16'(c_CHK));

    // Frame 4: channel 7 returns zero, commands channel 5.
    spi_frame(16'h2800, 16, w_word, w_bit, w_rdy);
    check_val("f4_miso", w_word,     16'h0000);
    check_val("f4_chnl", 16'(chnl),  16'd5);

    // Reset mid-frame while MISO is driving a 1 from batt.
    SS_n = 1'b0;
    wait_clks(10);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0;
      MOSI = 1'b0;
      wait_clks(5);
      SCLK = 1'b1;
      wait_clks(5);
    end
    check_val("mid_miso_pre", 16'(MISO), 16'h1);
    rst_n = 1'b0;
    #1;
    check_val("mr_miso", 16'(MISO),    16'h0);
    check_val("mr_chnl", 16'(chnl),    16'h0);
    check_val("mr_err",  16'(cmd_err), 16'h0);
    SS_n = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    check_val("mr_idle_miso", 16'(MISO), 16'h0);

    // First frame after reset returns channel 0 data.
    spi_frame(16'h2800, 16, w_word, w_bit, w_rdy);
    check_val("pr_miso", w_word,        16'h0ABC);
    check_val("pr_chnl", 16'(chnl),     16'd5);
    check_val("pr_rdy",  16'(w_rdy),    16'd1);
    check_val("pr_err",  16'(cmd_err),  16'h0);

    // Overlong frame: 17 rises, extra bit reads zero, command still taken.
    spi_frame(16'h2000, 17, w_word, w_bit, w_rdy);
    check_val("ol_miso", w_word,        16'h0FFF);
    check_val("ol_bit17", 16'(w_bit),   16'h0);
    check_val("ol_chnl", 16'(chnl),     16'd4);
    check_val("ol_rdy",  16'(w_rdy),    16'd1);
    check_val("ol_err",  16'(cmd_err),  16'(c_CHK));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
